// File: rtl/l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache. One transaction at a
// time, round-robin on ties, and a one-cycle release gap after every response.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
  input  logic                  l2_mem_resp
);

  // Handshake: a requester holds read/write high until it sees its resp for
  // one cycle; resp is forwarded combinationally from L2 to the granted side only.
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  state_e state_q, state_d;
  logic   last_served_q, last_served_d;  // 0 = I served last, 1 = D served last
  logic   i_req, d_req;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = last_served_q ? GRANT_I : GRANT_D;
        else if (i_req)     state_d = GRANT_I;
        else if (d_req)     state_d = GRANT_D;
      end
      GRANT_I: begin
        if (l2_mem_resp) begin
          last_served_d = 1'b0;
          state_d       = RELEASE;
        end else if (!i_req) begin
          // Requester abandoned the transaction; no credit for the turn.
          state_d = RELEASE;
        end
      end
      GRANT_D: begin
        if (l2_mem_resp) begin
          last_served_d = 1'b1;
          state_d       = RELEASE;
        end else if (!d_req) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  // Output mux is decoded from the registered state, so reset clears it at once.
  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    i_mem_resp     = 1'b0;
    d_mem_resp     = 1'b0;
    case (state_q)
      GRANT_I: begin
        l2_mem_read    = i_mem_read;
        l2_mem_address = i_mem_address;
        i_mem_resp     = l2_mem_resp;
      end
      GRANT_D: begin
        l2_mem_read    = d_mem_read & ~d_mem_write;
        l2_mem_write   = d_mem_write;
        l2_mem_address = d_mem_address;
        l2_mem_wdata   = d_mem_wdata;
        d_mem_resp     = l2_mem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a transaction-level model of ownership is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_l2_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_address = '0;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_address = '0;
  logic [LW-1:0] d_mem_wdata = '0;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          l2_mem_read;
  logic          l2_mem_write;
  logic [AW-1:0] l2_mem_address;
  logic [LW-1:0] l2_mem_wdata;
  logic [LW-1:0] l2_mem_rdata = '0;
  logic          l2_mem_resp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_rdata(l2_mem_rdata), .l2_mem_resp(l2_mem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = I-cache, 2 = D-cache. gap marks the one dead
  // cycle after a transaction in which no new owner can be chosen.
  int owner;
  bit gap;
  bit last_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= 0;
      gap    <= 1'b0;
      last_d <= 1'b1;
    end else if (owner == 0) begin
      if (gap) gap <= 1'b0;
      else if (i_mem_read && (d_mem_read || d_mem_write)) owner <= last_d ? 1 : 2;
      else if (i_mem_read) owner <= 1;
      else if (d_mem_read || d_mem_write) owner <= 2;
    end else if (l2_mem_resp) begin
      last_d <= (owner == 2);
      owner  <= 0;
      gap    <= 1'b1;
    end else if ((owner == 1 && !i_mem_read) || (owner == 2 && !(d_mem_read || d_mem_write))) begin
      owner <= 0;
      gap   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      check("l2_mem_read", LW'(l2_mem_read),
            LW'(owner == 1 ? i_mem_read : owner == 2 ? (d_mem_read && !d_mem_write) : 1'b0));
      check("l2_mem_write", LW'(l2_mem_write), LW'(owner == 2 ? d_mem_write : 1'b0));
      check("l2_mem_address", LW'(l2_mem_address),
            LW'(owner == 1 ? i_mem_address : owner == 2 ? d_mem_address : '0));
      check("l2_mem_wdata", l2_mem_wdata, owner == 2 ? d_mem_wdata : '0);
      check("i_mem_resp", LW'(i_mem_resp), LW'(owner == 1 && l2_mem_resp));
      check("d_mem_resp", LW'(d_mem_resp), LW'(owner == 2 && l2_mem_resp));
      check("i_mem_rdata", i_mem_rdata, l2_mem_rdata);
      check("d_mem_rdata", d_mem_rdata, l2_mem_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Counts cycles until an L2 request appears; returns the address seen.
  task automatic wait_grant(output int gap_cycles, output logic [AW-1:0] addr);
    gap_cycles = 0;
    while (!(l2_mem_read || l2_mem_write) && gap_cycles < 20) begin
      tick();
      gap_cycles++;
    end
    if (!(l2_mem_read || l2_mem_write)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_grant timeout at %0t: got no request expected request", $time);
    end
    addr = l2_mem_address;
  endtask

  // Holds the request for lat cycles in total, then raises resp with data.
  task automatic respond(input int lat, input logic [LW-1:0] data);
    repeat (lat - 1) tick();
    l2_mem_resp  = 1'b1;
    l2_mem_rdata = data;
    #1;
  endtask

  // Ends the response cycle; caller sets request levels after this.
  task automatic end_resp();
    tick();
    l2_mem_resp = 1'b0;
  endtask

  // ---------------- scoreboard of grant order ----------------
  logic [AW-1:0] exp_q[$];

  task automatic expect_grant(input string name, input int gap_cycles, input int exp_gap,
                              input logic [AW-1:0] addr);
    logic [AW-1:0] exp_addr;
    check({name, "_gap"}, LW'(gap_cycles), LW'(exp_gap));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got grant %0h expected none", name, addr);
    end else begin
      exp_addr = exp_q.pop_front();
      check({name, "_addr"}, LW'(addr), LW'(exp_addr));
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int g;
    logic [AW-1:0] a;
    logic [LW-1:0] a5, wd;
    a5 = {32{8'hA5}};
    wd = {8{32'h1234_5678}};

    // Reset state
    #2;
    check("reset_l2_read", LW'(l2_mem_read), '0);
    check("reset_resp", LW'({i_mem_resp, d_mem_resp}), '0);
    do_reset();

    // 1: lone I read, resp on third request cycle
    i_mem_read = 1'b1;
    i_mem_address = 32'h0000_1000;
    exp_q.push_back(32'h0000_1000);
    wait_grant(g, a);
    expect_grant("t1", g, 1, a);
    respond(3, a5);
    check("t1_i_resp", LW'(i_mem_resp), LW'(1));
    check("t1_i_rdata", i_mem_rdata, a5);
    check("t1_d_resp", LW'(d_mem_resp), '0);
    end_resp();
    i_mem_read = 1'b0;
    check("t1_release_read", LW'(l2_mem_read), '0);
    tick();

    // 2: simultaneous requests after reset, I first
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 32'h100;
    d_mem_read = 1'b1; d_mem_address = 32'h200;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    wait_grant(g, a);
    expect_grant("t2_first", g, 1, a);
    respond(1, 256'h11);
    end_resp();
    i_mem_read = 1'b0;
    wait_grant(g, a);
    expect_grant("t2_second", g, 2, a);
    respond(2, 256'h22);
    check("t2_d_resp", LW'(d_mem_resp), LW'(1));
    end_resp();
    d_mem_read = 1'b0;

    // 3: continuous requests alternate I, D, I, D with 2-cycle gaps
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? 32'h100 : 32'h200);
      wait_grant(g, a);
      expect_grant("t3", g, 2, a);
      respond(1 + k, LW'(k + 100));
      check("t3_i_resp", LW'(i_mem_resp), LW'(k % 2 == 0));
      check("t3_d_resp", LW'(d_mem_resp), LW'(k % 2 == 1));
      end_resp();
    end
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;

    // 4: writeback with read also high; write wins
    d_mem_write = 1'b1; d_mem_read = 1'b1;
    d_mem_address = 32'h300; d_mem_wdata = wd;
    exp_q.push_back(32'h300);
    wait_grant(g, a);
    expect_grant("t4", g, 2, a);
    check("t4_write", LW'(l2_mem_write), LW'(1));
    check("t4_read", LW'(l2_mem_read), '0);
    check("t4_wdata", l2_mem_wdata, wd);
    respond(2, '0);
    end_resp();
    d_mem_write = 1'b0;

    // 5: I arrives while D is held by a 10-cycle L2 stall
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h400);
    wait_grant(g, a);
    expect_grant("t5_d", g, 2, a);
    i_mem_read = 1'b1; i_mem_address = 32'h400;
    respond(11, 256'h55);
    check("t5_hold_addr", LW'(l2_mem_address), LW'(32'h300));
    check("t5_i_resp", LW'(i_mem_resp), '0);
    end_resp();
    d_mem_read = 1'b0;
    wait_grant(g, a);
    expect_grant("t5_i", g, 2, a);
    respond(1, 256'h66);
    end_resp();

    // 6: I abandons its request; stray resp afterwards is not forwarded
    exp_q.push_back(32'h400);
    wait_grant(g, a);
    expect_grant("t6", g, 2, a);
    i_mem_read = 1'b0;
    #1;
    check("t6_drop_read", LW'(l2_mem_read), '0);
    tick();
    l2_mem_resp = 1'b1;
    #1;
    check("t6_stray_resp", LW'({i_mem_resp, d_mem_resp}), '0);
    tick();
    check("t6_stray_resp_idle", LW'({i_mem_resp, d_mem_resp}), '0);
    l2_mem_resp = 1'b0;
    tick();

    // 7: reset in the middle of a D grant
    d_mem_read = 1'b1; d_mem_address = 32'h500;
    exp_q.push_back(32'h500);
    wait_grant(g, a);
    expect_grant("t7_d", g, 1, a);
    i_mem_read = 1'b1; i_mem_address = 32'h600;
    tick();
    rst = 1'b1;
    #1;
    check("t7_rst_req", LW'({l2_mem_read, l2_mem_write}), '0);
    check("t7_rst_resp", LW'({i_mem_resp, d_mem_resp}), '0);
    check("t7_rst_addr", LW'(l2_mem_address), '0);
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h600);
    wait_grant(g, a);
    expect_grant("t7_after", g, 1, a);
    respond(1, 256'h77);
    end_resp();
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;
    tick();
    tick();

    check("exp_q_empty", LW'(exp_q.size()), '0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
